// File: rtl/gcd_pkg.sv
// Shared definitions for the parametrised GCD coprocessor.
//   state_t    : engine FSM states (IDLE waits for a request, CALC iterates)
//   MODE_SUB   : subtractive Euclid algorithm select
//   MODE_STEIN : binary Stein algorithm select
package gcd_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam logic MODE_SUB   = 1'b0;
  localparam logic MODE_STEIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration in either algorithm.
//   mode_i          : MODE_SUB or MODE_STEIN
//   a_i, b_i, k_i   : current operands and Stein common-power-of-two count
//   a_o, b_o, k_o   : operands and count after one step
//   eq_o            : operands are equal, so the run is complete
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K_W   = $clog2(WIDTH) + 1
) (
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [K_W-1:0]   k_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [K_W-1:0]   k_o,
  output logic             eq_o
);

  always_comb begin
    a_o  = a_i;
    b_o  = b_i;
    k_o  = k_i;
    eq_o = (a_i == b_i);
    if (!eq_o) begin
      if (mode_i == MODE_SUB) begin
        if (a_i < b_i) b_o = b_i - a_i;
        else           a_o = a_i - b_i;
      end else begin
        // Stein: strip shared factors of two first, then lone factors,
        // and only subtract once both operands are odd.
        if (!a_i[0] && !b_i[0]) begin
          a_o = a_i >> 1;
          b_o = b_i >> 1;
          k_o = k_i + K_W'(1);
        end else if (!a_i[0]) begin
          a_o = a_i >> 1;
        end else if (!b_i[0]) begin
          b_o = b_i >> 1;
        end else if (a_i < b_i) begin
          b_o = b_i - a_i;
        end else begin
          a_o = a_i - b_i;
        end
      end
    end
  end

endmodule

// File: rtl/gcd_engine_param.sv
// Parametrised GCD coprocessor engine (subtractive Euclid or binary Stein).
//   clk, reset         : clock, asynchronous active-high reset
//   clk_en             : step enable; everything but done freezes when low
//   start, abort, mode : request, cancel, algorithm select (sampled at accept)
//   op_a, op_b         : operands (sampled at accept)
//   result, iter       : last GCD, step count of last/current run (saturating)
//   busy, done         : computing, one-cycle completion pulse
//   zero_err, aborted  : both operands were zero, last run was cancelled
module gcd_engine_param
  import gcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 16,
  parameter int K_W    = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  output logic [WIDTH-1:0]  result,
  output logic [ITER_W-1:0] iter,
  output logic              busy,
  output logic              done,
  output logic              zero_err,
  output logic              aborted
);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                mode_q, mode_d;
  logic                done_q, done_d;
  logic                zero_err_q, zero_err_d;
  logic                aborted_q, aborted_d;

  logic [WIDTH-1:0]    step_a, step_b;
  logic [K_W-1:0]      step_k;
  logic                step_eq;

  function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
    return (&v) ? v : v + ITER_W'(1);
  endfunction

  gcd_step #(.WIDTH(WIDTH), .K_W(K_W)) u_step (
    .mode_i (mode_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .k_i    (k_q),
    .a_o    (step_a),
    .b_o    (step_b),
    .k_o    (step_k),
    .eq_o   (step_eq)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      iter_q     <= '0;
      result_q   <= '0;
      mode_q     <= MODE_SUB;
      done_q     <= 1'b0;
      zero_err_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      k_q        <= k_d;
      iter_q     <= iter_d;
      result_q   <= result_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      zero_err_q <= zero_err_d;
      aborted_q  <= aborted_d;
    end
  end

  // Next-state logic; done_d defaults low so the pulse always self-clears,
  // even on edges where clk_en is low.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    k_d        = k_q;
    iter_d     = iter_q;
    result_d   = result_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    zero_err_d = zero_err_q;
    aborted_d  = aborted_q;
    case (state_q)
      IDLE: begin
        if (start && clk_en && !abort) begin
          a_d        = op_a;
          b_d        = op_b;
          k_d        = '0;
          iter_d     = '0;
          mode_d     = mode;
          aborted_d  = 1'b0;
          zero_err_d = (op_a == '0) && (op_b == '0);
          // gcd(x, 0) = x, so a zero operand completes without iterating.
          if ((op_a == '0) || (op_b == '0)) begin
            result_d = op_a | op_b;
            done_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (clk_en) begin
          if (step_eq) begin
            result_d = a_q << k_q;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            a_d    = step_a;
            b_d    = step_b;
            k_d    = step_k;
            iter_d = sat_inc(iter_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    result   = result_q;
    iter     = iter_q;
    busy     = (state_q == CALC);
    done     = done_q;
    zero_err = zero_err_q;
    aborted  = aborted_q;
  end

endmodule

// File: tb/tb_gcd_engine_param.sv
// Self-checking bench for gcd_engine_param: directed scenarios plus random
// operands checked against an arithmetic reference model.
module tb_gcd_engine_param;

  logic        clk = 1'b0;
  logic        reset, clk_en, start, abort, mode;
  logic [31:0] op_a, op_b, result;
  logic [15:0] iter;
  logic        busy, done, zero_err, aborted;

  logic        start8;
  logic [7:0]  op_a8, op_b8, result8;
  logic [3:0]  iter8;
  logic        busy8, done8, zero_err8, aborted8;

  int errors = 0;
  int checks = 0;

  gcd_engine_param dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .abort(abort),
    .mode(mode), .op_a(op_a), .op_b(op_b), .result(result), .iter(iter),
    .busy(busy), .done(done), .zero_err(zero_err), .aborted(aborted)
  );

  gcd_engine_param #(.WIDTH(8), .ITER_W(4)) dut8 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start8), .abort(abort),
    .mode(mode), .op_a(op_a8), .op_b(op_b8), .result(result8), .iter(iter8),
    .busy(busy8), .done(done8), .zero_err(zero_err8), .aborted(aborted8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Greatest common divisor via the remainder form of Euclid.
  function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned r;
    while (b != 0) begin
      r = a % b;
      a = b;
      b = r;
    end
    return a;
  endfunction

  // Subtractive steps = sum of Euclid quotients, less the final one that
  // would reach zero instead of stopping at equality.
  function automatic int ref_sub_steps(input longint unsigned a, input longint unsigned b);
    longint unsigned x, y, r;
    int n = 0;
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    while (y != 0) begin
      n += int'(x / y);
      r = x % y;
      x = y;
      y = r;
    end
    return n - 1;
  endfunction

  // Stein step count from the algorithm's rule list.
  function automatic int ref_stein_steps(input longint unsigned a, input longint unsigned b);
    int n = 0;
    while (a != b) begin
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
      n++;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input logic m, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mode = m; op_a = a; op_b = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Edges after accept until done is seen; -1 if the bound expires.
  task automatic wait_done(input int max_edges, output int edges);
    edges = 0;
    for (int i = 0; i < max_edges; i++) begin
      step();
      edges++;
      if (done) return;
    end
    edges = -1;
  endtask

  int  e, n, lat;
  logic saw_done;
  logic m;
  logic [31:0] ra, rb;
  longint unsigned g;

  initial begin
    reset = 1'b0; clk_en = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    op_a = '0; op_b = '0; start8 = 1'b0; op_a8 = '0; op_b8 = '0;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_iter", iter, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {zero_err, aborted}, 0);
    step();
    reset = 1'b0;

    // Subtractive 12/18
    launch(1'b0, 32'd12, 32'd18);
    chk("sub_busy_after_accept", busy, 1);
    wait_done(100, e);
    chk("sub_latency", e, 3);
    chk("sub_result", result, 6);
    chk("sub_iter", iter, 2);
    chk("sub_busy_end", busy, 0);
    step();
    chk("sub_done_one_cycle", done, 0);

    // Stein 12/18
    launch(1'b1, 32'd12, 32'd18);
    wait_done(100, e);
    chk("stein_latency", e, 5);
    chk("stein_result", result, 6);
    chk("stein_iter", iter, 4);

    // Abort, with start held during CALC
    launch(1'b0, 32'd1000, 32'd7);
    saw_done = 1'b0;
    start = 1'b1; op_a = 32'd3; op_b = 32'd3;
    step(); saw_done |= done;
    step(); saw_done |= done;
    start = 1'b0;
    chk("busy_start_ignored_iter", iter, 2);
    chk("busy_start_ignored_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin step(); saw_done |= done; end
    chk("abort_pre_iter", iter, 5);
    abort = 1'b1;
    step(); saw_done |= done;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_flag", aborted, 1);
    chk("abort_result_held", result, 6);
    step(); saw_done |= done;
    chk("abort_no_done", saw_done, 0);

    // abort in IDLE blocks start
    start = 1'b1; abort = 1'b1; op_a = 32'd12; op_b = 32'd18;
    step();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_done", done, 0);
    chk("idle_abort_flag_kept", aborted, 1);

    // Zero operands
    launch(1'b0, 32'd0, 32'd35);
    chk("zero_b_done", done, 1);
    chk("zero_b_result", result, 35);
    chk("zero_b_zero_err", zero_err, 0);
    chk("zero_b_busy", busy, 0);
    chk("zero_b_aborted_cleared", aborted, 0);
    step();
    chk("zero_b_done_clear", done, 0);
    launch(1'b1, 32'd0, 32'd0);
    chk("zero_both_done", done, 1);
    chk("zero_both_result", result, 0);
    chk("zero_both_zero_err", zero_err, 1);
    chk("zero_both_iter", iter, 0);

    // clk_en gating 1-of-3, Stein 255/15
    n = ref_stein_steps(255, 15);
    @(negedge clk);
    mode = 1'b1; op_a = 32'd255; op_b = 32'd15; start = 1'b1; clk_en = 1'b1;
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      step();
      start = 1'b0;
      if (done) begin lat = c; break; end
      clk_en = ((c + 1) % 3 == 0);
    end
    chk("clken_latency", lat, 3 * (n + 1));
    chk("clken_result", result, 15);
    chk("clken_iter", iter, n);
    clk_en = 1'b0;
    step();
    chk("clken_done_clears_when_gated", done, 0);
    clk_en = 1'b1;

    // Random operands against the reference model
    for (int t = 0; t < 8; t++) begin
      m  = 1'($urandom_range(0, 1));
      ra = $urandom_range(1, 3000);
      rb = $urandom_range(1, 3000);
      g  = ref_gcd(ra, rb);
      n  = m ? ref_stein_steps(ra, rb) : ref_sub_steps(ra, rb);
      launch(m, ra, rb);
      wait_done(n + 10, e);
      chk($sformatf("rnd%0d_latency", t), e, n + 1);
      chk($sformatf("rnd%0d_result", t), result, g);
      chk($sformatf("rnd%0d_iter", t), iter, n);
      chk($sformatf("rnd%0d_zero_err", t), zero_err, 0);
    end

    // Reset mid-CALC
    launch(1'b0, 32'd1000, 32'd7);
    step(); step(); step();
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_iter", iter, 0);
    chk("midrst_result", result, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    // WIDTH=8 / ITER_W=4 saturation
    @(negedge clk);
    mode = 1'b0; op_a8 = 8'd255; op_b8 = 8'd1; start8 = 1'b1; clk_en = 1'b1;
    step();
    start8 = 1'b0;
    e = -1;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (done8) begin e = i; break; end
    end
    chk("w8_latency", e, 255);
    chk("w8_result", result8, 1);
    chk("w8_iter_saturated", iter8, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_engine_param.md
Name: gcd_engine_param

Overview:
- Parametrised GCD coprocessor behind the gpioemu register interface.
- Generalises the fixed 32-bit subtractive engine:
  - configurable operand width;
  - selectable algorithm: subtractive Euclid or binary Stein;
  - zero-operand handling;
  - abort;
  - saturating iteration counter.
- Register-decode logic loads A1/A2/mode and pulses start. The engine returns result, iter count, busy, a done pulse and status flags for readback.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- ITER_W, 16, width of the iteration counter (saturates at all-ones).
- K_W, $clog2(WIDTH)+1, width of the Stein common-power-of-two counter.

Ports:
- clk  in  1  system clock (1 kHz in gpioemu).
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  step enable; when low, all state except done freezes.
- start  in  1  request; accepted only in IDLE with clk_en=1.
- abort  in  1  cancels a running computation.
- mode  in  1  0 = subtractive Euclid, 1 = binary Stein; sampled at accept.
- op_a  in  WIDTH  operand A; sampled at accept.
- op_b  in  WIDTH  operand B; sampled at accept.
- result  out  WIDTH  last GCD; holds until the next completion.
- iter  out  ITER_W  CALC steps of the last/current run.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse on completion.
- zero_err  out  1  last accepted run had op_a = op_b = 0.
- aborted  out  1  last run was aborted; cleared on next accept.

Behaviour:
- Reset (async):
  - state = IDLE.
  - result, iter, a, b, k = 0.
  - busy, done, zero_err, aborted = 0.
- done is cleared on every clk edge unconditionally, clk_en notwithstanding. It is high for exactly one cycle.
- States: IDLE, CALC.
- IDLE, accept edge (start=1, clk_en=1, abort=0):
  - a←op_a, b←op_b, k←0, iter←0, mode latched.
  - aborted←0, zero_err←(op_a==0 && op_b==0).
  - If op_a==0 or op_b==0: result←op_a|op_b, done←1, stay in IDLE (1-edge latency, iter=0).
  - Otherwise: state←CALC, busy←1.
- CALC, each edge with clk_en=1:
  - a==b: result←a<<k (subtractive: k is always 0), done←1, busy←0, state←IDLE. iter is not incremented.
  - Subtractive, a≠b: if a<b then b←b−a, else a←a−b.
  - Stein, a≠b, priority order:
    - both even: a>>=1, b>>=1, k++;
    - a even: a>>=1;
    - b even: b>>=1;
    - both odd: larger ← larger − smaller.
  - Every non-final step: iter ← iter+1, saturating at 2^ITER_W−1.
- abort=1 in CALC (clk_en ignored): state←IDLE, busy←0, aborted←1, no done, result unchanged.
- abort=1 in IDLE: start is ignored that cycle; no state change.
- start while busy: ignored; operands not resampled.
- clk_en=0: no accept and no step. busy, iter, result, a, b, k hold.
- Arithmetic is unsigned WIDTH-bit. Subtraction never underflows because the larger operand is always minuend. The result of a<<k never exceeds max(op_a, op_b), so it fits in WIDTH.
- Reset mid-CALC: immediate return to reset values; no done.

Decomposition:
- gcd_pkg:
  - state enum {IDLE, CALC};
  - MODE_SUB=1'b0, MODE_STEIN=1'b1.
- Sub-module gcd_step: combinational next-(a, b, k) plus an "equal" flag for one step in either mode. It is instantiated once inside gcd_engine_param, which owns the FSM, counters and output registers.

Test Plan:
- Subtractive: mode=0, op_a=12, op_b=18, start.
  - Expect busy after the accept edge and done on the 3rd CALC edge.
  - Expect result=6, iter=2.
- Stein: mode=1, op_a=12, op_b=18.
  - Step sequence (6,9,k1) → (3,9) → (3,6) → (3,3).
  - Expect result=6, iter=4.
- Zero operands:
  - op_a=0, op_b=35: done one edge after accept, result=35, zero_err=0, busy never high.
  - op_a=op_b=0: result=0, zero_err=1.
- Abort/start interplay: start 1000/7 in mode 0, abort after 5 CALC edges.
  - Expect busy=0, aborted=1, no done pulse, result unchanged.
  - Start asserted while busy is ignored (iter continues uninterrupted).
- clk_en gating and reset: toggle clk_en 1-of-3 during 255/15 in mode 1.
  - Expect the same result=15 and iter, with latency stretched ×3.
  - Assert reset mid-CALC: all outputs return to 0 asynchronously.
- Parameter sweep: WIDTH=8, ITER_W=4, mode=0, op_a=255, op_b=1.
  - Expect result=1 and iter saturated at 15.
  - Expect done after 254 steps + the final compare edge.
